sample_arb: RTL and testbench
=============================

SAMPLE_ARB -- requirements
Module: sample_arb

Interface
REQ-001 SHALL have parameter: HOLD_MAX, 10, maximum cycles an owner holds the bus in OWN (legal 1..255).
REQ-002 SHALL have parameter: DW, 8, data width of each requester port and of dout.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: req  in  3  per-requester bus request; bit i = requester i.
REQ-006 SHALL have port: rel  in  3  per-requester release strobe; ignored unless bit = current owner.
REQ-007 SHALL have port: d0, d1, d2  in  DW each  requester write data.
REQ-008 SHALL have port: grant  out  3  one-hot grant, all-zero when no owner.
REQ-009 SHALL have port: owner  out  2  index of owner; 2'd3 = none.
REQ-010 SHALL have port: bus_oe  out  1  drive-enable for the shared inout bus.
REQ-011 SHALL have port: dout  out  DW  registered data of current owner.
REQ-012 SHALL have port: timeout  out  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL implement FSM IDLE, GRANT, OWN, TURN; all outputs registered.
REQ-014 IDLE: if any req bit high at edge N, SHALL enter GRANT at N with grant/owner set to the winner; else stay IDLE.
REQ-015 GRANT: one cycle, bus_oe=0; SHALL enter OWN at next edge, setting bus_oe=1 and loading hold counter to 0.
REQ-016 OWN: every edge, dout SHALL load the owner's data (d0/d1/d2) and counter SHALL increment by 1 (8-bit, no wrap needed since HOLD_MAX<=255).
REQ-017 OWN exit to TURN SHALL occur when rel[owner]=1, req[owner]=0, or counter==HOLD_MAX-1.
REQ-018 timeout SHALL pulse for the single cycle after the OWN->TURN edge only when exit cause is counter limit and neither rel[owner] nor loss of req[owner] is present; simultaneous release and limit count as release, no pulse.
REQ-019 TURN: one cycle, grant=0, owner=3, bus_oe=0, dout holds last value; SHALL then go to IDLE (no back-to-back grant without turnaround).
REQ-020 GRANT with req[owner] dropped SHALL still proceed to OWN and exit on the following edge via REQ-017 (minimum OWN length 1 cycle).
REQ-021 rel bits of non-owners and req changes of non-owners SHALL not affect state.
REQ-022 Default arbitration SHALL be fixed priority req[0] > req[1] > req[2].
REQ-023 bus_oe SHALL be 1 only in OWN; grant SHALL be nonzero only in GRANT and OWN.

Reset
REQ-024 On rst_n low, SHALL immediately force: state IDLE, grant=0, owner=3, bus_oe=0, dout=0, timeout=0, counter=0, RR pointer=0.
REQ-025 Reset asserted mid-OWN SHALL drop bus_oe asynchronously, same cycle; first grant after release follows REQ-014.

Configuration
REQ-026 Macro SAMPLE_ARB_RR_EN defined: arbitration SHALL be round-robin; priority search starts at (last owner + 1) mod 3; pointer updated on OWN->TURN; after reset search starts at requester 0.
REQ-027 SAMPLE_ARB_RR_EN undefined: fixed priority per REQ-022; no pointer register.

Verification
REQ-028 req=3'b110 from IDLE -> grant=3'b010, owner=1 next cycle; bus_oe=1 one cycle later; dout=d1.
REQ-029 req[0] held high, no rel, HOLD_MAX=10 -> bus_oe high exactly 10 cycles, timeout pulse 1 cycle, TURN 1 cycle, re-grant to 0.
REQ-030 Owner 2, rel=3'b100 on 3rd OWN cycle with counter limit not reached -> TURN next edge, timeout stays 0; rel=3'b001 alone ignored.
REQ-031 rst_n low during OWN -> bus_oe, grant, dout 0 same cycle; rst_n high with req=3'b001 -> grant=3'b001 after one edge.
REQ-032 req=3'b111 held, each owner releases after 2 cycles -> without SAMPLE_ARB_RR_EN owner sequence 0,0,0; with it 0,1,2,0.
REQ-033 HOLD_MAX=1, rel[owner] asserted on the only OWN cycle -> TURN, timeout=0.

Source files
------------

// File: rtl/sample_arb.sv
// sample_arb: three-requester bus arbiter with a grant cycle, bounded ownership and a turnaround cycle.
// Define SAMPLE_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority 0 > 1 > 2.
module sample_arb #(
    parameter int HOLD_MAX = 10,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    req,
    input  logic [2:0]    rel,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    output logic [2:0]    grant,
    output logic [1:0]    owner,
    output logic          bus_oe,
    output logic [DW-1:0] dout,
    output logic          timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_OWN     = 2'd2;
    localparam logic [1:0] ST_TURN    = 2'd3;
    localparam logic [1:0] OWNER_NONE = 2'd3;
    localparam logic [7:0] CNT_LIMIT  = 8'(HOLD_MAX - 1);

    function automatic logic bit_of(input logic [2:0] v, input logic [1:0] idx);
        logic b;
        case (idx)
            2'd0:    b = v[0];
            2'd1:    b = v[1];
            2'd2:    b = v[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] onehot_of(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic [DW-1:0] data_of(input logic [1:0] idx, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [DW-1:0] c);
        logic [DW-1:0] v;
        case (idx)
            2'd0:    v = a;
            2'd1:    v = b;
            2'd2:    v = c;
            default: v = {DW{1'b0}};
        endcase
        return v;
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
    endfunction

    // First requesting index found scanning upward (mod 3) from start; OWNER_NONE if none.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        idx   = start;
        win   = OWNER_NONE;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && bit_of(r, idx)) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
            end
            idx = next_idx(idx);
        end
        return win;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [1:0]    owner_q, owner_d;
    logic          bus_oe_q, bus_oe_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    winner_s;
    logic          rel_own_s;
    logic          req_own_s;
    logic          at_limit_s;

`ifdef SAMPLE_ARB_RR_EN
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    assign winner_s = pick(req, rr_ptr_q);
`else
    assign winner_s = pick(req, 2'd0);
`endif

    assign rel_own_s  = bit_of(rel, owner_q);
    assign req_own_s  = bit_of(req, owner_q);
    assign at_limit_s = (cnt_q == CNT_LIMIT);

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        bus_oe_d  = bus_oe_q;
        dout_d    = dout_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef SAMPLE_ARB_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (winner_s != OWNER_NONE) begin
                    state_d = ST_GRANT;
                    owner_d = winner_s;
                    grant_d = onehot_of(winner_s);
                end else begin
                    grant_d  = 3'b000;
                    owner_d  = OWNER_NONE;
                    bus_oe_d = 1'b0;
                end
            end
            ST_GRANT: begin
                state_d  = ST_OWN;
                bus_oe_d = 1'b1;
                cnt_d    = 8'd0;
                dout_d   = data_of(owner_q, d0, d1, d2);
            end
            ST_OWN: begin
                dout_d = data_of(owner_q, d0, d1, d2);
                cnt_d  = cnt_q + 8'd1;
                if (rel_own_s || !req_own_s || at_limit_s) begin
                    state_d   = ST_TURN;
                    grant_d   = 3'b000;
                    owner_d   = OWNER_NONE;
                    bus_oe_d  = 1'b0;
                    // Release or request loss takes precedence over the hold limit.
                    timeout_d = at_limit_s && !rel_own_s && req_own_s;
`ifdef SAMPLE_ARB_RR_EN
                    rr_ptr_d  = next_idx(owner_q);
`endif
                end else begin
                    state_d = ST_OWN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = 3'b000;
                owner_d  = OWNER_NONE;
                bus_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'b000;
            owner_q   <= OWNER_NONE;
            bus_oe_q  <= 1'b0;
            dout_q    <= {DW{1'b0}};
            timeout_q <= 1'b0;
            cnt_q     <= 8'd0;
`ifdef SAMPLE_ARB_RR_EN
            rr_ptr_q  <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            bus_oe_q  <= bus_oe_d;
            dout_q    <= dout_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
`ifdef SAMPLE_ARB_RR_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign bus_oe  = bus_oe_q;
    assign dout    = dout_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sample_arb.sv
// Testbench for sample_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_sample_arb;

    localparam int HOLD = 10;
`ifdef SAMPLE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req, rel, req1, rel1;
    logic [7:0] d0, d1, d2;
    logic [2:0] grant, grant1;
    logic [1:0] owner, owner1;
    logic       bus_oe, bus_oe1, timeout, timeout1;
    logic [7:0] dout, dout1;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    sample_arb #(.HOLD_MAX(HOLD), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .d0(d0), .d1(d1), .d2(d2),
        .grant(grant), .owner(owner), .bus_oe(bus_oe), .dout(dout), .timeout(timeout)
    );

    sample_arb #(.HOLD_MAX(1), .DW(8)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .rel(rel1), .d0(d0), .d1(d1), .d2(d2),
        .grant(grant1), .owner(owner1), .bus_oe(bus_oe1), .dout(dout1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 waiting, 1 granted, 2 holding the bus, 3 turnaround.
    typedef struct {
        int         phase;
        int         who;
        int         held;
        int         start;
        logic [7:0] data;
        logic       pulse;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.phase = 0; r.who = -1; r.held = 0; r.start = 0; r.data = 8'h00; r.pulse = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] sel(input int i, input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
        if (i == 0) return a;
        else if (i == 1) return b;
        else return c;
    endfunction

    function automatic model_t model_next(input model_t s, input logic [2:0] rq, input logic [2:0] rl,
                                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        model_t n;
        int w;
        n = s;
        n.pulse = 1'b0;
        if (s.phase == 0) begin
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (s.start + k) % 3;
                if (w < 0 && rq[idx]) w = idx;
            end
            if (w >= 0) begin
                n.who = w;
                n.phase = 1;
            end
        end else if (s.phase == 1) begin
            n.phase = 2;
            n.held = 0;
            n.data = sel(s.who, a, b, c);
        end else if (s.phase == 2) begin
            n.data = sel(s.who, a, b, c);
            n.held = s.held + 1;
            if (rl[s.who] || !rq[s.who] || n.held == HOLD) begin
                n.pulse = (n.held == HOLD) && !rl[s.who] && rq[s.who];
                if (RR) n.start = (s.who + 1) % 3;
                n.who = -1;
                n.phase = 3;
            end
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, req, rel, d0, d1, d2);
    end

    logic [2:0] e_grant;
    logic [1:0] e_owner;
    logic       e_oe;

    always_comb begin
        e_grant = 3'b000;
        e_owner = 2'd3;
        e_oe    = (m.phase == 2);
        if (m.phase == 1 || m.phase == 2) begin
            e_grant = 3'b001 << m.who;
            e_owner = 2'(m.who);
        end
    end

    // Single compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                n_vec++;
                if ({grant, owner, bus_oe, timeout, dout} !== {e_grant, e_owner, e_oe, m.pulse, m.data}) begin
                    n_err++;
                    $display("FAIL model_cmp t=%0t: dut grant=%b owner=%0d oe=%b to=%b dout=%h; want grant=%b owner=%0d oe=%b to=%b dout=%h",
                             $time, grant, owner, bus_oe, timeout, dout, e_grant, e_owner, e_oe, m.pulse, m.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic       oe_s [0:39];
    logic       to_s [0:39];
    logic [2:0] gr_s [0:39];
    int         seq [$];
    int         exp_seq [4];

    initial begin
        int i0, len, oc;
        logic [2:0] prev_g;
        rst_n = 1'b0; req = 3'b000; rel = 3'b000; req1 = 3'b000; rel1 = 3'b000;
        d0 = 8'h11; d1 = 8'h5A; d2 = 8'hC3;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_owner", 32'(owner), 32'h3);
        check("rst_oe", 32'(bus_oe), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        tick();

        // Requesters 1 and 2 from idle: requester 1 wins, drives the bus one cycle later.
        req = 3'b110;
        tick();
        check("r028_grant", 32'(grant), 32'h2);
        check("r028_owner", 32'(owner), 32'h1);
        check("r028_oe_in_grant", 32'(bus_oe), 32'h0);
        check("model_pin_grant", 32'(e_grant), 32'h2);
        tick();
        check("r028_oe", 32'(bus_oe), 32'h1);
        check("r028_dout", 32'(dout), 32'h5A);
        req = 3'b000;
        tick();
        check("r028_turn_oe", 32'(bus_oe), 32'h0);
        check("r028_turn_owner", 32'(owner), 32'h3);
        check("r028_turn_to", 32'(timeout), 32'h0);
        tick();

        // Requester 0 holds until the hold limit forces release.
        req = 3'b001;
        for (int c = 0; c < 40; c++) begin
            tick();
            oe_s[c] = bus_oe; to_s[c] = timeout; gr_s[c] = grant;
        end
        i0 = -1; len = 0;
        for (int c = 0; c < 40; c++) if (i0 < 0 && oe_s[c]) i0 = c;
        if (i0 >= 0) while (i0 + len < 40 && oe_s[i0 + len]) len++;
        check("r029_hold_len", 32'(len), 32'd10);
        if (i0 >= 1 && i0 + len + 2 < 40) begin
            check("r029_to_before", 32'(to_s[i0 + len - 1]), 32'h0);
            check("r029_to_pulse", 32'(to_s[i0 + len]), 32'h1);
            check("r029_to_after", 32'(to_s[i0 + len + 1]), 32'h0);
            check("r029_turn_grant", 32'(gr_s[i0 + len]), 32'h0);
            check("r029_regrant", 32'(gr_s[i0 + len + 2]), 32'h1);
        end else begin
            n_vec++; n_err++;
            $display("FAIL r029_window: bus_oe start %0d length %0d, expected start >= 1 with 10 cycles", i0, len);
        end
        req = 3'b000;
        repeat (5) tick();

        // Owner 2 releases on its third cycle; a non-owner release before that is ignored.
        req = 3'b100;
        tick();
        check("r030_owner", 32'(owner), 32'h2);
        tick();
        tick();
        rel = 3'b001;
        tick();
        check("r030_ign_oe", 32'(bus_oe), 32'h1);
        check("r030_ign_owner", 32'(owner), 32'h2);
        rel = 3'b100;
        tick();
        check("r030_rel_oe", 32'(bus_oe), 32'h0);
        check("r030_rel_owner", 32'(owner), 32'h3);
        check("r030_rel_to", 32'(timeout), 32'h0);
        rel = 3'b000; req = 3'b000;
        repeat (3) tick();

        // Reset in the middle of an ownership cycle.
        d0 = 8'h77; req = 3'b001;
        tick();
        tick();
        check("r031_oe_before", 32'(bus_oe), 32'h1);
        check("r031_dout_before", 32'(dout), 32'h77);
        #2 rst_n = 1'b0;
        #1;
        check("r031_oe_async", 32'(bus_oe), 32'h0);
        check("r031_grant_async", 32'(grant), 32'h0);
        check("r031_dout_async", 32'(dout), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("r031_regrant", 32'(grant), 32'h1);
        req = 3'b000;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // All three requesting, each owner releasing on its second cycle.
        if (RR) begin
            exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 0;
        end else begin
            exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
        end
        req = 3'b111; oc = 0; prev_g = 3'b000;
        for (int c = 0; c < 80 && seq.size() < 4; c++) begin
            tick();
            if (grant != 3'b000 && prev_g == 3'b000) seq.push_back(int'(owner));
            prev_g = grant;
            if (bus_oe) oc++;
            else oc = 0;
            rel = (oc == 2) ? grant : 3'b000;
        end
        rel = 3'b000; req = 3'b000;
        if (seq.size() < 4) begin
            n_vec++; n_err++;
            $display("FAIL r032_seq_len: saw %0d grants, expected 4 within 80 cycles", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) check($sformatf("r032_owner%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
        end
        repeat (5) tick();

        // HOLD_MAX=1 instance: release on the only cycle, then a limit-forced exit.
        req1 = 3'b001;
        tick();
        check("r033_grant", 32'(grant1), 32'h1);
        tick();
        check("r033_oe", 32'(bus_oe1), 32'h1);
        rel1 = 3'b001;
        tick();
        check("r033_rel_oe", 32'(bus_oe1), 32'h0);
        check("r033_rel_owner", 32'(owner1), 32'h3);
        check("r033_rel_to", 32'(timeout1), 32'h0);
        rel1 = 3'b000;
        tick();
        tick();
        tick();
        check("r033_oe2", 32'(bus_oe1), 32'h1);
        tick();
        check("r033_limit_to", 32'(timeout1), 32'h1);
        check("r033_limit_oe", 32'(bus_oe1), 32'h0);
        req1 = 3'b000;
        repeat (3) tick();

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) rel = 3'b001 << $urandom_range(0, 2);
            else rel = 3'b000;
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            tick();
        end
        rst_n = 1'b1; req = 3'b000; rel = 3'b000;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
